pipe_decode: RTL and testbench
==============================

# pipe_decode

Parametrised instruction-decode stage for the five-stage MIPS pipeline, sitting between fetch and execute. It owns the register file and decodes add/sub/slt/lw/sw/beq/j. It adds a valid/ready handshake to both neighbours, load-use hazard stalling, write-back bypass, sign-extended immediates and in-decode branch/jump resolution. All state is clocked on `clk` with synchronous active-high `rst`.

## Interface
Parameters:
- `XLEN`, 32: datapath width, at least 32.
- `NREG`, 32: architectural register count, a power of two; `RW = $clog2(NREG)`.
- `ACW`, 3: ALUctr width.

Ports:
- `clk`  in  1  rising-edge clock, the single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `if_valid`  in  1  fetch presents an instruction.
- `if_ready`  out  1  decode accepts the instruction this cycle.
- `ir`  in  32  instruction word.
- `pc`  in  XLEN  address of `ir`.
- `ext_stall`  in  1  external hazard; forces `if_ready` to 0.
- `wb_en`  in  1  write-back strobe.
- `wb_rd`  in  RW  write-back destination.
- `wb_data`  in  XLEN  write-back value.
- `ex_ready`  in  1  execute can take the DX register.
- `dx_valid`  out  1  DX register holds an operation.
- `dx_a`, `dx_b`, `dx_sdata`  out  XLEN  rs value, operand B, and store data (rt).
- `dx_rd`  out  RW  destination register; 0 means no write.
- `dx_aluctr`  out  ACW  ALU operation.
- `dx_lw`, `dx_sw`  out  1  load and store flags.
- `br_taken`  out  1  one-cycle redirect pulse.
- `br_target`  out  XLEN  redirect address, valid while `br_taken`=1.
- `illegal`  out  1  one-cycle pulse on an unsupported accepted opcode or funct.

## Operation
- Accept: `fire = if_valid & if_ready`. Advance: `adv = ex_ready | ~dx_valid`. `if_ready = adv & ~hazard & ~ext_stall`.
- Hazard: `dx_valid & dx_rd≠0 & dx_rd∈{rs, rt used by ir} & (dx_lw | ir is beq)`.
  - While a hazard holds, `dx_valid` drops to 0 (bubble) provided `adv` is 1.
  - No hazard when `dx_rd`=0.
- Operand read goes through the regfile with bypass: `wb_en & wb_rd≠0 & wb_rd==src` returns `wb_data`. Register 0 always reads 0, and writes to it are dropped.
- Decode on fire:
  - R-type add/sub/slt (funct 32/34/42): `B=R[rt]`, `rd=ir[15:11]`, `aluctr` = 0/1/2.
  - lw (35): `B=sext(imm16)`, `rd=rt`, `aluctr=0`, `dx_lw=1`.
  - sw (43): `B=sext(imm16)`, `dx_sdata=R[rt]`, `rd=0`, `aluctr=0`, `dx_sw=1`.
  - beq (4): `dx_valid=0`. If `R[rs]==R[rt]`, `br_taken=1` and `br_target = pc+4+(sext(imm16)<<2)`.
  - j (2): `dx_valid=0`, `br_taken=1`, `br_target = {(pc+4)[XLEN-1:28], ir[25:0], 2'b00}`.
  - Anything else: `dx_valid=0`, `illegal=1`.
- Accepted instructions of every other kind drive `br_taken=0`.
- Fetch squashes its in-flight word on `br_taken`. Decode does not flush itself.
- When `adv=1` and `fire=0`, `dx_valid` is set to 0. When `adv=0`, every DX output holds.
- Arithmetic is modulo 2^XLEN. `sext` extends bit 15 to XLEN.

## Timing
- Reset (`rst`=1 at a clock edge): every output register clears to 0, including `dx_valid`, `br_taken` and `illegal`. All NREG registers clear to 0. `if_ready` reads 0 during reset.
- Reset wins over a simultaneous write-back or fire. A reset mid-stall discards the stalled instruction.
- Latency: fire at edge N → DX outputs, `br_taken` and `illegal` valid after edge N+1, for one cycle or until `adv`.
- Register file write happens at the edge. A same-cycle read sees the new value through the bypass.
- Load-use costs exactly one bubble cycle when `ex_ready` stays high.
- beq behind any DX writer of its sources costs one bubble. Writers further downstream are covered by `ext_stall`.
- `if_ready` is combinational from `dx_valid`, `dx_rd`, `dx_lw`, `ir`, `ex_ready` and `ext_stall`. There is no path from `if_valid` to `if_ready`.

## Structure
- `pipe_pkg` holds:
  - opcode constants OP_RTYPE/OP_LW/OP_SW/OP_BEQ/OP_J;
  - funct constants FN_ADD/FN_SUB/FN_SLT;
  - the ALUctr enum ALU_ADD=0, ALU_SUB=1, ALU_SLT=2.
- Sub-module `pipe_regfile` (parameters XLEN, NREG): 2 read ports, 1 write port, write-first bypass, r0 hardwired to zero, synchronous clear.
- `pipe_decode` holds the decode logic, hazard logic and DX/redirect registers.

## Test plan
- Reset: hold `rst` 2 cycles, then release. All outputs read 0, `if_ready`=1 with `ex_ready`=1, and reading R5 returns 0.
- Bypass: `wb_en=1`, `wb_rd=3`, `wb_data=0x11`, same cycle as fire of `add $4,$3,$0` → next cycle `dx_a=0x11`, `dx_rd=4`, `dx_aluctr=0`.
- Load-use: `lw $2,-4($1)` then `sub $5,$2,$6` → lw issues with `dx_b=0xFFFFFFFC`. `if_ready=0` for 1 cycle with one bubble, then sub issues with `dx_aluctr=1`.
- beq: with R1=R2=7 and pc=0x100, fire `beq $1,$2,+3` → `br_taken=1` for 1 cycle, `br_target=0x110`, `dx_valid=0`. Then fire j with `ir[25:0]=0x40` → `br_target=0x100`.
- Backpressure: `ex_ready=0` for 3 cycles with `dx_valid=1` → DX outputs stable and `if_ready=0`. Releasing `ex_ready` advances exactly once.
- Illegal/r0: opcode 0x3F → `illegal` pulse and `dx_valid=0`. A write-back of 0x55 to r0 → r0 still reads 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared opcode, funct and ALU-control encodings for the decode stage
package pipe_pkg;
  localparam logic [5:0] OP_RTYPE = 6'd0, OP_LW = 6'd35, OP_SW = 6'd43, OP_BEQ = 6'd4, OP_J = 6'd2;
  localparam logic [5:0] FN_ADD = 6'd32, FN_SUB = 6'd34, FN_SLT = 6'd42;
  typedef enum logic [2:0] {ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_SLT = 3'd2} alu_e;
endpackage

// File: rtl/pipe_regfile.sv
// pipe_regfile: 2R1W register file, write-first bypass, r0 hardwired to zero
module pipe_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int RW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RW-1:0]   ra1,
  input  logic [RW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [RW-1:0]   wa,
  input  logic [XLEN-1:0] wd
);
  logic [XLEN-1:0] mem_q [NREG];
  logic [XLEN-1:0] mem_d [NREG];
  always_comb begin
    mem_d = mem_q;
    if (we && wa != '0) mem_d[wa] = wd;
  end
  assign rd1 = mem_d[ra1];
  assign rd2 = mem_d[ra2];
  always_ff @(posedge clk) begin
    if (rst) mem_q <= '{default: '0};
    else mem_q <= mem_d;
  end
endmodule

// File: rtl/pipe_decode.sv
// pipe_decode: MIPS decode stage with handshake, load-use stall, bypass and branch resolution
module pipe_decode import pipe_pkg::*; #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int ACW = 3,
  localparam int RW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     ir,
  input  logic [XLEN-1:0] pc,
  input  logic            ext_stall,
  input  logic            wb_en,
  input  logic [RW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_ready,
  output logic            dx_valid,
  output logic [XLEN-1:0] dx_a,
  output logic [XLEN-1:0] dx_b,
  output logic [XLEN-1:0] dx_sdata,
  output logic [RW-1:0]   dx_rd,
  output logic [ACW-1:0]  dx_aluctr,
  output logic            dx_lw,
  output logic            dx_sw,
  output logic            br_taken,
  output logic [XLEN-1:0] br_target,
  output logic            illegal
);
  logic [5:0] op, fn;
  logic [RW-1:0] rs, rt, rd_f;
  logic [XLEN-1:0] rs_val, rt_val, imm, pc4, br_tgt, j_tgt;
  logic is_r, r_ok, is_lw, is_sw, is_beq, is_j, issue, uses_rs, uses_rt, hazard, adv, fire;
  logic unused_shamt;
  logic dx_valid_q, dx_valid_d, dx_lw_q, dx_lw_d, dx_sw_q, dx_sw_d;
  logic br_taken_q, br_taken_d, illegal_q, illegal_d;
  logic [XLEN-1:0] dx_a_q, dx_a_d, dx_b_q, dx_b_d, dx_sdata_q, dx_sdata_d, br_target_q, br_target_d;
  logic [RW-1:0] dx_rd_q, dx_rd_d;
  logic [ACW-1:0] dx_aluctr_q, dx_aluctr_d;
  pipe_regfile #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clk(clk), .rst(rst), .ra1(rs), .ra2(rt), .rd1(rs_val), .rd2(rt_val),
    .we(wb_en), .wa(wb_rd), .wd(wb_data)
  );
  assign op = ir[31:26];
  assign fn = ir[5:0];
  assign rs = RW'(ir[25:21]);
  assign rt = RW'(ir[20:16]);
  assign rd_f = RW'(ir[15:11]);
  assign unused_shamt = ^ir[10:6];
  assign imm = {{(XLEN-16){ir[15]}}, ir[15:0]};
  assign pc4 = pc + XLEN'(4);
  assign br_tgt = pc4 + (imm << 2);
  assign j_tgt = {pc4[XLEN-1:28], ir[25:0], 2'b00};
  assign is_r = op == OP_RTYPE;
  assign r_ok = is_r && (fn == FN_ADD || fn == FN_SUB || fn == FN_SLT);
  assign is_lw = op == OP_LW;
  assign is_sw = op == OP_SW;
  assign is_beq = op == OP_BEQ;
  assign is_j = op == OP_J;
  assign issue = r_ok | is_lw | is_sw;
  assign uses_rs = is_r | is_lw | is_sw | is_beq;
  assign uses_rt = is_r | is_sw | is_beq;
  assign hazard = dx_valid_q && dx_rd_q != '0 && (dx_lw_q || is_beq) &&
                  ((uses_rs && dx_rd_q == rs) || (uses_rt && dx_rd_q == rt));
  assign adv = ex_ready | ~dx_valid_q;
  assign if_ready = adv & ~hazard & ~ext_stall & ~rst;
  assign fire = if_valid & if_ready;
  always_comb begin
    dx_valid_d = adv ? fire & issue : dx_valid_q;
    dx_a_d = fire ? rs_val : dx_a_q;
    dx_b_d = fire ? (is_r ? rt_val : imm) : dx_b_q;
    dx_sdata_d = fire ? rt_val : dx_sdata_q;
    dx_rd_d = fire ? (r_ok ? rd_f : is_lw ? rt : '0) : dx_rd_q;
    dx_aluctr_d = !fire ? dx_aluctr_q : (is_r && fn == FN_SUB) ? ACW'(ALU_SUB) :
                  (is_r && fn == FN_SLT) ? ACW'(ALU_SLT) : ACW'(ALU_ADD);
    dx_lw_d = fire ? is_lw : dx_lw_q;
    dx_sw_d = fire ? is_sw : dx_sw_q;
    br_taken_d = fire & (is_j | (is_beq & (rs_val == rt_val)));
    br_target_d = br_taken_d ? (is_j ? j_tgt : br_tgt) : br_target_q;
    illegal_d = fire & ~(issue | is_beq | is_j);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      dx_valid_q <= 1'b0;
      dx_a_q <= '0;
      dx_b_q <= '0;
      dx_sdata_q <= '0;
      dx_rd_q <= '0;
      dx_aluctr_q <= '0;
      dx_lw_q <= 1'b0;
      dx_sw_q <= 1'b0;
      br_taken_q <= 1'b0;
      br_target_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      dx_valid_q <= dx_valid_d;
      dx_a_q <= dx_a_d;
      dx_b_q <= dx_b_d;
      dx_sdata_q <= dx_sdata_d;
      dx_rd_q <= dx_rd_d;
      dx_aluctr_q <= dx_aluctr_d;
      dx_lw_q <= dx_lw_d;
      dx_sw_q <= dx_sw_d;
      br_taken_q <= br_taken_d;
      br_target_q <= br_target_d;
      illegal_q <= illegal_d;
    end
  end
  assign dx_valid = dx_valid_q;
  assign dx_a = dx_a_q;
  assign dx_b = dx_b_q;
  assign dx_sdata = dx_sdata_q;
  assign dx_rd = dx_rd_q;
  assign dx_aluctr = dx_aluctr_q;
  assign dx_lw = dx_lw_q;
  assign dx_sw = dx_sw_q;
  assign br_taken = br_taken_q;
  assign br_target = br_target_q;
  assign illegal = illegal_q;
endmodule

// File: tb/tb_pipe_decode.sv
// tb_pipe_decode: vector table plus hand sequences, checked through an output scoreboard
module tb_pipe_decode;
  logic clk = 0, rst = 1, if_valid = 0, ext_stall = 0, wb_en = 0, ex_ready = 1;
  logic [31:0] ir = 0, pc = 0, wb_data = 0;
  logic [4:0] wb_rd = 0;
  logic if_ready, dx_valid, dx_lw, dx_sw, br_taken, illegal;
  logic [31:0] dx_a, dx_b, dx_sdata, br_target;
  logic [4:0] dx_rd;
  logic [2:0] dx_aluctr;
  typedef struct packed {
    logic [1:0] kind;
    logic [31:0] a, b, sd;
    logic [4:0] rd;
    logic [2:0] alu;
    logic lw, sw;
    logic [31:0] tgt;
  } rec_t;
  typedef struct {
    logic [31:0] ir, pc;
    rec_t exp;
  } vec_t;
  localparam logic [1:0] K_DX = 0, K_BR = 1, K_ILL = 2, K_NONE = 3;
  vec_t vecs[14];
  rec_t q[$];
  int checks = 0, errors = 0;
  pipe_decode dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready), .ir(ir), .pc(pc),
    .ext_stall(ext_stall), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .ex_ready(ex_ready),
    .dx_valid(dx_valid), .dx_a(dx_a), .dx_b(dx_b), .dx_sdata(dx_sdata), .dx_rd(dx_rd),
    .dx_aluctr(dx_aluctr), .dx_lw(dx_lw), .dx_sw(dx_sw), .br_taken(br_taken),
    .br_target(br_target), .illegal(illegal)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] rt_i(int rs, int rt, int rd, int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction
  function automatic logic [31:0] it_i(int op, int rs, int rt, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] j_i(int op, int addr);
    return {6'(op), 26'(addr)};
  endfunction
  function automatic rec_t dx(logic [31:0] a, logic [31:0] b, logic [31:0] sd, int rd, int alu, bit lw, bit sw);
    return '{kind: K_DX, a: a, b: b, sd: sd, rd: 5'(rd), alu: 3'(alu), lw: lw, sw: sw, tgt: 32'd0};
  endfunction
  function automatic rec_t mk(logic [1:0] k, logic [31:0] tgt);
    return '{kind: k, a: 0, b: 0, sd: 0, rd: 0, alu: 0, lw: 0, sw: 0, tgt: tgt};
  endfunction
  task automatic chk(string nm, logic [139:0] act, logic [139:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic got(rec_t a);
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_output: got %h expected nothing", a);
    end else chk("scoreboard", a, q.pop_front());
  endtask
  always @(negedge clk) if (!rst) begin
    if (dx_valid && ex_ready)
      got('{kind: K_DX, a: dx_a, b: dx_b, sd: dx_sdata, rd: dx_rd, alu: dx_aluctr, lw: dx_lw, sw: dx_sw, tgt: 32'd0});
    if (br_taken) got(mk(K_BR, br_target));
    if (illegal) got(mk(K_ILL, 0));
  end
  task automatic issue(logic [31:0] i, logic [31:0] p, rec_t e);
    int n = 0;
    ir = i;
    pc = p;
    if_valid = 1;
    @(negedge clk);
    while (!if_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!if_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got if_ready=0 expected 1 for ir %h", i);
    end else if (e.kind != K_NONE) q.push_back(e);
    @(posedge clk);
    #1 if_valid = 0;
  endtask
  task automatic wb_write(int r, logic [31:0] d);
    wb_en = 1;
    wb_rd = 5'(r);
    wb_data = d;
    @(posedge clk);
    #1 wb_en = 0;
  endtask
  initial begin
    vecs[0]  = '{rt_i(1, 3, 4, 32), 32'h0, dx(7, 32'h33, 32'h33, 4, 0, 0, 0)};
    vecs[1]  = '{rt_i(6, 1, 9, 34), 32'h0, dx(32'h20, 7, 7, 9, 1, 0, 0)};
    vecs[2]  = '{rt_i(7, 6, 10, 42), 32'h0, dx(32'h80000000, 32'h20, 32'h20, 10, 2, 0, 0)};
    vecs[3]  = '{it_i(35, 6, 11, 8), 32'h0, dx(32'h20, 8, 0, 11, 0, 1, 0)};
    vecs[4]  = '{it_i(43, 6, 1, -16), 32'h0, dx(32'h20, 32'hFFFFFFF0, 7, 0, 0, 0, 1)};
    vecs[5]  = '{it_i(4, 1, 2, 3), 32'h100, mk(K_BR, 32'h110)};
    vecs[6]  = '{it_i(4, 1, 3, 3), 32'h100, mk(K_NONE, 0)};
    vecs[7]  = '{j_i(2, 32'h40), 32'h100, mk(K_BR, 32'h100)};
    vecs[8]  = '{j_i(2, 32'h40), 32'hF0000000, mk(K_BR, 32'hF0000100)};
    vecs[9]  = '{it_i(4, 1, 2, -2), 32'h200, mk(K_BR, 32'h1FC)};
    vecs[10] = '{j_i(63, 0), 32'h0, mk(K_ILL, 0)};
    vecs[11] = '{rt_i(1, 2, 3, 37), 32'h0, mk(K_ILL, 0)};
    vecs[12] = '{rt_i(1, 1, 0, 32), 32'h0, dx(7, 7, 7, 0, 0, 0, 0)};
    vecs[13] = '{rt_i(5, 0, 8, 32), 32'h0, dx(0, 0, 0, 8, 0, 0, 0)};
    @(negedge clk);
    chk("rst_if_ready", if_ready, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_outputs", {dx_valid, br_taken, illegal, dx_a, dx_b, dx_sdata, dx_rd, dx_aluctr, dx_lw, dx_sw, br_target}, 0);
    chk("rst_ready", if_ready, 1);
    @(posedge clk);
    #1;
    wb_write(1, 7);
    wb_write(2, 7);
    wb_write(3, 32'h33);
    wb_write(6, 32'h20);
    wb_write(7, 32'h80000000);
    for (int i = 0; i < 14; i++) issue(vecs[i].ir, vecs[i].pc, vecs[i].exp);
    wb_en = 1;
    wb_rd = 3;
    wb_data = 32'h11;
    issue(rt_i(3, 0, 4, 32), 0, dx(32'h11, 0, 0, 4, 0, 0, 0));
    wb_en = 0;
    ir = it_i(35, 1, 2, -4);
    if_valid = 1;
    @(negedge clk);
    chk("lu_lw_ready", if_ready, 1);
    q.push_back(dx(7, 32'hFFFFFFFC, 7, 2, 0, 1, 0));
    @(posedge clk);
    #1 ir = rt_i(2, 6, 5, 34);
    @(negedge clk);
    chk("lu_stall", if_ready, 0);
    @(negedge clk);
    chk("lu_bubble", {if_ready, dx_valid}, 2'b10);
    q.push_back(dx(7, 32'h20, 32'h20, 5, 1, 0, 0));
    @(posedge clk);
    #1 if_valid = 0;
    issue(rt_i(1, 1, 15, 32), 0, dx(7, 7, 7, 15, 0, 0, 0));
    ir = it_i(4, 15, 0, 1);
    pc = 32'h300;
    if_valid = 1;
    @(negedge clk);
    chk("beq_hazard", if_ready, 0);
    issue(it_i(4, 15, 0, 1), 32'h300, mk(K_BR, 32'h308));
    issue(rt_i(1, 6, 12, 32), 0, dx(7, 32'h20, 32'h20, 12, 0, 0, 0));
    ex_ready = 0;
    ir = rt_i(6, 6, 13, 32);
    if_valid = 1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold", {dx_valid, if_ready, dx_a, dx_rd}, {1'b1, 1'b0, 32'h7, 5'd12});
    end
    @(posedge clk);
    #1 ex_ready = 1;
    issue(rt_i(6, 6, 13, 32), 0, dx(32'h20, 32'h20, 32'h20, 13, 0, 0, 0));
    ext_stall = 1;
    @(negedge clk);
    chk("ext_stall", if_ready, 0);
    @(posedge clk);
    #1 ext_stall = 0;
    wb_en = 1;
    wb_rd = 0;
    wb_data = 32'h55;
    issue(rt_i(0, 0, 14, 32), 0, dx(0, 0, 0, 14, 0, 0, 0));
    wb_en = 0;
    issue(rt_i(0, 0, 14, 34), 0, dx(0, 0, 0, 14, 1, 0, 0));
    for (int n = 0; n < 20 && q.size() != 0; n++) @(negedge clk);
    chk("drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
